// File: rtl/nway_dcache.sv
// rtl/nway_dcache.sv - N-way set-associative write-back data cache with tree PLRU; optional NWAY_DCACHE_PERF_EN counters
module nway_dcache #(
  parameter int S_OFF   = 5,
  parameter int S_INDEX = 3,
  parameter int WAYS    = 4,
  parameter int S_TAG   = 32 - S_OFF - S_INDEX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read,
  input  logic                      write,
  input  logic [3:0]                wmask,
  input  logic [31:0]               address,
  input  logic [31:0]               wdata,
  output logic                      resp,
  output logic [31:0]               rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_addr,
  output logic [8*(2**S_OFF)-1:0]   mem_wdata,
  input  logic [8*(2**S_OFF)-1:0]   mem_rdata,
  input  logic                      mem_resp
`ifdef NWAY_DCACHE_PERF_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
  output logic [31:0]               wb_count
`endif
);

  localparam int LINE   = 8 * (2 ** S_OFF);
  localparam int SETS   = 2 ** S_INDEX;
  localparam int LW     = $clog2(WAYS);
  localparam int S_WORD = S_OFF - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_e;
  state_e state_q, state_d;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;
  logic             we_q;
  logic [LW-1:0]    victim_q;

  logic [LINE-1:0]  data_q  [SETS][WAYS];
  logic [S_TAG-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];

  logic [S_INDEX-1:0] idx;
  logic [S_TAG-1:0]   tag;
  logic [S_WORD-1:0]  word;
  logic               unused_addr_bits;

  assign idx  = addr_q[S_OFF +: S_INDEX];
  assign tag  = addr_q[31 -: S_TAG];
  assign word = addr_q[2 +: S_WORD];
  assign unused_addr_bits = ^{address[1:0], addr_q[1:0]};

  logic             hit;
  logic [LW-1:0]    hit_way;
  logic [LW-1:0]    plru_way;
  logic [LW-1:0]    victim_sel;
  logic             victim_dirty;
  logic [WAYS-2:0]  plru_next;
  logic [LINE-1:0]  hit_line;
  logic [LINE-1:0]  merged_line;

  // Tag match, victim choice (lowest invalid, else PLRU walk), PLRU update and write merge
  always_comb begin
    int node;
    hit         = 1'b0;
    hit_way     = '0;
    plru_way    = '0;
    plru_next   = plru_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = LW'(w);
      end
    end
    node = 1;
    for (int l = LW - 1; l >= 0; l--) begin
      plru_way[l] = plru_q[idx][node-1];
      node        = 2 * node + int'(plru_q[idx][node-1]);
    end
    victim_sel = plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim_sel = LW'(w);
    end
    victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];
    node = 1;
    for (int l = LW - 1; l >= 0; l--) begin
      plru_next[node-1] = ~hit_way[l];
      node              = 2 * node + int'(hit_way[l]);
    end
    hit_line    = data_q[idx][hit_way];
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (wmask_q[b]) merged_line[32*int'(word) + 8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Next state and outputs
  always_comb begin
    state_d   = state_q;
    resp      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    rdata     = hit_line[32*int'(word) +: 32];
    mem_wdata = data_q[idx][victim_q];
    case (state_q)
      IDLE: begin
        if (read || write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp    = 1'b1;
          state_d = IDLE;
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx][victim_q], idx, {S_OFF{1'b0}}};
        if (mem_resp) state_d = FILL;
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {tag, idx, {S_OFF{1'b0}}};
        if (mem_resp) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch and victim latch
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (read || write)) begin
      addr_q  <= address;
      wdata_q <= wdata;
      wmask_q <= wmask;
      we_q    <= write;
    end
    if (state_q == COMPARE && !hit) victim_q <= victim_sel;
  end

  // Valid, dirty and PLRU metadata; cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == COMPARE && hit) begin
        plru_q[idx] <= plru_next;
        if (we_q) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (state_q == FILL && mem_resp) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line data and tags; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == COMPARE && hit && we_q) data_q[idx][hit_way] <= merged_line;
      if (state_q == FILL && mem_resp) begin
        data_q[idx][victim_q] <= mem_rdata;
        tag_q[idx][victim_q]  <= tag;
      end
    end
  end

`ifdef NWAY_DCACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (state_q == COMPARE && hit && hit_count_q != 32'hFFFF_FFFF)
        hit_count_q <= hit_count_q + 32'd1;
      if (state_q == COMPARE && !hit && miss_count_q != 32'hFFFF_FFFF)
        miss_count_q <= miss_count_q + 32'd1;
      if (state_q == WRITEBACK && mem_resp && wb_count_q != 32'hFFFF_FFFF)
        wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule
